// File: rtl/input_port_rc_buffer.sv
// Input-port flit FIFO with XY route computation on the head flit.
// The head path is combinational from the FIFO; misrouted heads are dropped automatically.
module input_port_rc_buffer #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int CUR_X    = 0,
    parameter int CUR_Y    = 2,
    parameter int HAS_W    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] data_in,
    input  logic                data_valid_in,
    output logic                full,
    input  logic                ready,
    output logic [3:0]          label,
    output logic [DATASIZE-1:0] data_out,
    output logic [7:0]          drop_cnt,
    output logic                overflow
);

    localparam logic [1:0]   CX    = CUR_X[1:0];
    localparam logic [1:0]   CY    = CUR_Y[1:0];
    localparam logic [WIDTH:0] DEPTH_C = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(DEPTH - 1);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [WIDTH-1:0]    rd_ptr, wr_ptr;
    logic [WIDTH:0]      count, count_nxt;
    logic [DATASIZE-1:0] head;
    logic [1:0]          dst_x, dst_y;
    logic [3:0]          route;
    logic                empty, misroute, push, pop, attempt;

    assign head  = mem[rd_ptr];
    assign dst_x = head[33:32];
    assign dst_y = head[35:34];
    assign empty = (count == '0);

    always_comb begin
        route = 4'b0000;
        if (dst_x > CX)      route = 4'b0010;
        else if (dst_x < CX) route = 4'b1000;
        else if (dst_y > CY) route = 4'b0001;
        else if (dst_y < CY) route = 4'b0100;
    end

    // A head routed West with no West output can never be granted, so it is flushed.
    assign misroute = !empty && (route == 4'b1000) && (HAS_W == 0);
    assign label    = (empty || misroute) ? 4'b1111 : route;
    assign data_out = empty ? '0 : head;

    // Null flits (type 00) are neither stored nor treated as push attempts.
    assign attempt = data_valid_in && (data_in[1:0] != 2'b00);
    assign push    = attempt && !full;
    assign pop     = !empty && (misroute || (ready && label != 4'b1111));

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            if (attempt && full)                 overflow <= 1'b1;
            if (misroute && drop_cnt != 8'hFF)   drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
